pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (F->D, D->E, E->M, M->W).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and
// the per-stage hold/bubble control pair.
package pipe_hazard_ctrl_pkg;

    localparam int DEF_REG_W  = 5;
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_IF = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: the instruction in decode reads a register that
// the load currently in execute has not produced yet. x0 is never a hazard.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_is_load,
    output logic             hazard
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare both decode sources against the pending load destination
    always_comb begin
        rs1_hit = d_use1 && (d_rs1 == e_rd);
        rs2_hit = d_use2 && (d_rs2 == e_rd);
        hazard  = e_is_load && (e_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the F->D, D->E, E->M and M->W stage
// registers. Stall/flush are combinational; the fetch redirect is registered
// and deferred until any outstanding ibus fetch has returned.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W  = DEF_REG_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ex_busy,
    input  logic [REG_W-1:0]  d_rs1,
    input  logic [REG_W-1:0]  d_rs2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic [REG_W-1:0]  e_rd,
    input  logic              e_is_load,
    input  logic              e_redirect,
    input  logic [ADDR_W-1:0] e_target,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    output logic [CNT_W-1:0]  stall_cycles
);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic              f_stall;
    stage_ctrl_t       d_ctrl;
    stage_ctrl_t       e_ctrl;
    stage_ctrl_t       m_ctrl;
    logic              load_use;
    logic              accept_redirect;
    logic              fire_direct;
    logic              fire_pending;
    logic [ADDR_W-1:0] pending_pc;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use (
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .d_use1    (d_use1),
        .d_use2    (d_use2),
        .e_rd      (e_rd),
        .e_is_load (e_is_load),
        .hazard    (load_use)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Priority resolution of stall/flush controls and next sequencer state
    always_comb begin
        state_next      = state;
        f_stall         = 1'b0;
        d_ctrl          = '0;
        e_ctrl          = '0;
        m_ctrl          = '0;
        accept_redirect = 1'b0;
        fire_direct     = 1'b0;
        fire_pending    = 1'b0;

        // The deferred redirect leaves as soon as the stale fetch returns,
        // independent of any back-end freeze.
        if (state == WAIT_IF && !if_busy) begin
            state_next   = RUN;
            fire_pending = 1'b1;
        end

        if (mem_busy) begin
            f_stall      = 1'b1;
            d_ctrl.stall = 1'b1;
            e_ctrl.stall = 1'b1;
            m_ctrl.stall = 1'b1;
        end else if (ex_busy) begin
            f_stall      = 1'b1;
            d_ctrl.stall = 1'b1;
            e_ctrl.stall = 1'b1;
            m_ctrl.flush = 1'b1;
        end else if (state == WAIT_IF) begin
            f_stall      = 1'b1;
            d_ctrl.flush = 1'b1;
        end else if (e_redirect) begin
            d_ctrl.flush    = 1'b1;
            e_ctrl.flush    = 1'b1;
            accept_redirect = 1'b1;
            if (if_busy) begin
                state_next = WAIT_IF;
            end else begin
                fire_direct = 1'b1;
            end
        end else if (load_use) begin
            f_stall      = 1'b1;
            d_ctrl.stall = 1'b1;
            e_ctrl.flush = 1'b1;
        end
    end

    // Redirect target capture and one-cycle redirect pulse to fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            pending_pc  <= '0;
        end else begin
            redir_valid <= fire_direct || fire_pending;
            if (accept_redirect) begin
                pending_pc <= e_target;
            end
            if (fire_direct) begin
                redir_pc <= e_target;
            end else if (fire_pending) begin
                redir_pc <= pending_pc;
            end
        end
    end

    // Performance counter of fetch-stall cycles, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (f_stall) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign stall_f = f_stall;
    assign stall_d = d_ctrl.stall;
    assign flush_d = d_ctrl.flush;
    assign stall_e = e_ctrl.stall;
    assign flush_e = e_ctrl.flush;
    assign stall_m = m_ctrl.stall;
    assign flush_m = m_ctrl.flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized cycles, all checked against a behavioural model of the rules.
module tb_pipe_hazard_ctrl;

    localparam int REG_W  = 5;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;

    localparam int ACT_NONE  = 0;
    localparam int ACT_MEM   = 1;
    localparam int ACT_EX    = 2;
    localparam int ACT_WAIT  = 3;
    localparam int ACT_REDIR = 4;
    localparam int ACT_LU    = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_busy, mem_busy, ex_busy;
    logic [REG_W-1:0]  d_rs1, d_rs2, e_rd;
    logic              d_use1, d_use2, e_is_load, e_redirect;
    logic [ADDR_W-1:0] e_target;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_m;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic [CNT_W-1:0]  stall_cycles;

    int compare_count = 0;
    int fail_count    = 0;

    // Reference model state
    bit                m_waiting = 1'b0;
    logic [ADDR_W-1:0] m_pending = '0;
    logic              m_rv      = 1'b0;
    logic [ADDR_W-1:0] m_rpc     = '0;
    logic [CNT_W-1:0]  m_cnt     = '0;

    pipe_hazard_ctrl #(
        .REG_W  (REG_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_busy      (if_busy),
        .mem_busy     (mem_busy),
        .ex_busy      (ex_busy),
        .d_rs1        (d_rs1),
        .d_rs2        (d_rs2),
        .d_use1       (d_use1),
        .d_use2       (d_use2),
        .e_rd         (e_rd),
        .e_is_load    (e_is_load),
        .e_redirect   (e_redirect),
        .e_target     (e_target),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_m      (flush_m),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Which rule governs the current cycle, highest priority first
    function automatic int model_action();
        bit hazard;
        hazard = e_is_load && (e_rd != 0) &&
                 ((d_use1 && d_rs1 == e_rd) || (d_use2 && d_rs2 == e_rd));
        if (mem_busy)        return ACT_MEM;
        if (ex_busy)         return ACT_EX;
        if (m_waiting)       return ACT_WAIT;
        if (e_redirect)      return ACT_REDIR;
        if (hazard)          return ACT_LU;
        return ACT_NONE;
    endfunction

    // Expected {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m}
    function automatic logic [6:0] model_ctrl(input int act);
        case (act)
            ACT_MEM:   return 7'b1111_000;
            ACT_EX:    return 7'b1110_001;
            ACT_WAIT:  return 7'b1000_100;
            ACT_REDIR: return 7'b0000_110;
            ACT_LU:    return 7'b1100_010;
            default:   return 7'b0000_000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the model just before the next edge
    task automatic check_output(input string tag);
        logic [6:0] exp;
        exp = model_ctrl(model_action());
        check({tag, ".stall_f"}, 64'(stall_f), 64'(exp[6]));
        check({tag, ".stall_d"}, 64'(stall_d), 64'(exp[5]));
        check({tag, ".stall_e"}, 64'(stall_e), 64'(exp[4]));
        check({tag, ".stall_m"}, 64'(stall_m), 64'(exp[3]));
        check({tag, ".flush_d"}, 64'(flush_d), 64'(exp[2]));
        check({tag, ".flush_e"}, 64'(flush_e), 64'(exp[1]));
        check({tag, ".flush_m"}, 64'(flush_m), 64'(exp[0]));
        check({tag, ".redir_valid"}, 64'(redir_valid), 64'(m_rv));
        check({tag, ".redir_pc"}, redir_pc, m_rpc);
        check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(m_cnt));
    endtask

    // Advance the model across one rising edge
    task automatic update_model();
        int  act;
        bit  was_waiting;
        logic [6:0] ctl;
        act = model_action();
        ctl = model_ctrl(act);
        was_waiting = m_waiting;
        if (reset) begin
            m_waiting = 1'b0;
            m_pending = '0;
            m_rv      = 1'b0;
            m_rpc     = '0;
            m_cnt     = '0;
        end else begin
            m_rv  = 1'b0;
            m_cnt = m_cnt + CNT_W'(ctl[6]);
            if (was_waiting && !if_busy) begin
                m_rv      = 1'b1;
                m_rpc     = m_pending;
                m_waiting = 1'b0;
            end
            if (act == ACT_REDIR) begin
                m_pending = e_target;
                if (if_busy) begin
                    m_waiting = 1'b1;
                end else begin
                    m_rv  = 1'b1;
                    m_rpc = e_target;
                end
            end
        end
    endtask

    // One clock: inputs already driven after a falling edge
    task automatic apply_stimulus(input string tag);
        #1;
        check_output(tag);
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic set_idle();
        if_busy    = 1'b0;
        mem_busy   = 1'b0;
        ex_busy    = 1'b0;
        d_rs1      = '0;
        d_rs2      = '0;
        d_use1     = 1'b0;
        d_use2     = 1'b0;
        e_rd       = '0;
        e_is_load  = 1'b0;
        e_redirect = 1'b0;
        e_target   = '0;
    endtask

    task automatic set_load_use();
        e_is_load = 1'b1;
        e_rd      = 5'd5;
        d_rs1     = 5'd5;
        d_use1    = 1'b1;
        d_rs2     = 5'd1;
        d_use2    = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        apply_stimulus("reset_hold");
        reset = 1'b0;
        apply_stimulus("reset_state");
        check("reset.stall_cycles", 64'(stall_cycles), 64'd0);

        // Load-use on x5: exactly one bubble
        set_load_use();
        apply_stimulus("lu_x5");
        set_idle();
        check("lu_x5.counter", 64'(stall_cycles), 64'd1);
        apply_stimulus("lu_after");

        // Load to x0 never stalls
        e_is_load = 1'b1; e_rd = 5'd0; d_rs1 = 5'd0; d_use1 = 1'b1; d_use2 = 1'b1;
        apply_stimulus("lu_x0");
        set_idle();

        // Redirect with fetch idle: pulse next cycle only
        e_redirect = 1'b1; e_target = 64'h8000_0040;
        apply_stimulus("redir_now");
        set_idle();
        check("redir_now.valid", 64'(redir_valid), 64'd1);
        check("redir_now.pc", redir_pc, 64'h8000_0040);
        apply_stimulus("redir_pulse");
        check("redir_now.drop", 64'(redir_valid), 64'd0);
        check("redir_now.hold", redir_pc, 64'h8000_0040);

        // Redirect deferred behind outstanding fetch
        e_redirect = 1'b1; e_target = 64'h0000_1234_5678_9ABC; if_busy = 1'b1;
        apply_stimulus("redir_defer");
        e_redirect = 1'b1; e_target = 64'hDEAD;
        for (int i = 0; i < 3; i++) apply_stimulus("wait_if");
        e_redirect = 1'b0; if_busy = 1'b0;
        apply_stimulus("wait_exit");
        check("defer.valid", 64'(redir_valid), 64'd1);
        check("defer.pc", redir_pc, 64'h0000_1234_5678_9ABC);
        apply_stimulus("defer_after");

        // mem_busy masks redirect and load-use; redirect then wins over load-use
        set_load_use();
        e_redirect = 1'b1; e_target = 64'h40; mem_busy = 1'b1;
        apply_stimulus("mem_busy_0");
        apply_stimulus("mem_busy_1");
        mem_busy = 1'b0; ex_busy = 1'b1;
        apply_stimulus("ex_busy");
        ex_busy = 1'b0;
        apply_stimulus("redir_over_lu");
        set_idle();
        check("redir_over_lu.pc", redir_pc, 64'h40);
        apply_stimulus("redir_over_lu_pulse");

        // Reset while waiting on the fetch discards the pending redirect
        e_redirect = 1'b1; e_target = 64'h7777; if_busy = 1'b1;
        apply_stimulus("pre_reset");
        e_redirect = 1'b0;
        apply_stimulus("in_wait");
        reset = 1'b1;
        apply_stimulus("reset_in_wait");
        reset = 1'b0; if_busy = 1'b0;
        apply_stimulus("post_reset");
        check("post_reset.valid", 64'(redir_valid), 64'd0);
        check("post_reset.pc", redir_pc, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if_busy    = ($urandom_range(0, 1) == 1);
            mem_busy   = ($urandom_range(0, 5) == 0);
            ex_busy    = ($urandom_range(0, 5) == 0);
            e_redirect = ($urandom_range(0, 3) == 0);
            e_target   = {$urandom, $urandom};
            e_is_load  = ($urandom_range(0, 1) == 1);
            e_rd       = REG_W'($urandom_range(0, 3));
            d_rs1      = REG_W'($urandom_range(0, 3));
            d_rs2      = REG_W'($urandom_range(0, 3));
            d_use1     = ($urandom_range(0, 1) == 1);
            d_use2     = ($urandom_range(0, 1) == 1);
            reset      = ($urandom_range(0, 99) == 0);
            apply_stimulus("rand");
        end
        reset = 1'b0;
        set_idle();
        apply_stimulus("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
